// File: rtl/soc_uart_rx.sv
// -----------------------------------------------------------------------------
// soc_uart_rx -- memory-mapped UART receiver for the picorv32 SoC.
//
// Samples rx_pin at the configured baud rate, assembles 8N1 frames (8E1 when
// the UART_RX_PARITY_EN macro is defined) and queues received bytes in a small
// FIFO that the CPU drains over the native picorv32 memory bus.
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data
// bits, mismatch sets STATUS bit 4 and discards the byte).
//
// Ports:
//   clk_cpu   system clock
//   n_reset   asynchronous active-low reset
//   rx_pin    serial line, idle high, asynchronous to clk_cpu
//   sel       address-decode hit for this block (already qualified by mem_valid)
//   wstrb     byte write strobes, nonzero means write
//   address   byte offset: 0x0 DATA (RO, pops), 0x4 STATUS (W1C bits 2..4)
//   wdata     write data
//   rdata     registered read data, valid while ready is high
//   ready     one-cycle bus acknowledge
//   irq       level interrupt, high while the FIFO holds data
// -----------------------------------------------------------------------------
module soc_uart_rx #(
  parameter int UART_CLK_HZ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk_cpu,
  input  logic        n_reset,
  input  logic        rx_pin,
  input  logic        sel,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);

  localparam int CLKS_PER_BIT = UART_CLK_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int PTR_W        = AW + 1;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  // ---------------------------------------------------------------------------
  // Front end: two-flop synchronizer plus one more flop for edge detection.
  // NOTE: these flops reset to 1 (line idle) so reset release never looks
  // like a start-bit falling edge.
  // ---------------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q, rx_s3_q;

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain; blocking
      // ones would collapse the three flops into one.
      rx_s1_q <= rx_pin;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  logic rx_sync, rx_fall;
  assign rx_sync = rx_s2_q;
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_req;
  logic             frame_set;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             par_set;
`endif

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_set   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = S_START;
      end
      S_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit hold an even count of ones.
          par_bad_d = rx_sync ^ (^shift_q);
          par_set   = rx_sync ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
            push_req = ~par_bad_q;
`else
            push_req = 1'b1;
`endif
            state_d  = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must return high before a new frame counts.
        cnt_d = '0;
        if (rx_sync) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. Pointers carry one extra bit so full and empty differ only
  // in the MSB.
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0] count;
  logic             empty, full, push, pop, overrun_set;
  logic             ready_q, pop_pend_q;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pending DATA read retires at the end of its ready cycle; when that
  // coincides with a push into a full FIFO, the slot it frees takes the byte.
  assign pop         = ready_q & pop_pend_q;
  assign push        = push_req & (~full | pop);
  assign overrun_set = push_req & full & ~pop;

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk_cpu) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus interface and sticky status flags
  // ---------------------------------------------------------------------------
  logic        req, is_wr, hit_data, hit_stat;
  logic        clr_w1c;
  logic        ovr_q, frm_q, par_flag;
  logic [31:0] status, rdata_q, rdata_d;

  assign req      = sel & ~ready_q;
  assign is_wr    = |wstrb;
  assign hit_data = (address == 4'h0);
  assign hit_stat = (address == 4'h4);
  assign clr_w1c  = req & is_wr & hit_stat;

  assign status = {16'h0, 8'(count), 3'b000, par_flag, frm_q, ovr_q, full, ~empty};

  always_comb begin
    rdata_d = rdata_q;
    if (req) begin
      rdata_d = '0;
      if (!is_wr && hit_data && !empty) rdata_d = {23'h0, 1'b1, mem_q[rd_ptr_q[AW-1:0]]};
      if (!is_wr && hit_stat)           rdata_d = status;
    end
  end

  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) begin
      ready_q    <= 1'b0;
      pop_pend_q <= 1'b0;
      rdata_q    <= '0;
      ovr_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      ready_q    <= req;
      pop_pend_q <= req & ~is_wr & hit_data & ~empty;
      rdata_q    <= rdata_d;
      // A new error in the same cycle as its clear wins, so it is never lost.
      ovr_q      <= (ovr_q & ~(clr_w1c & wdata[2])) | overrun_set;
      frm_q      <= (frm_q & ~(clr_w1c & wdata[3])) | frame_set;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk_cpu or negedge n_reset) begin
    if (!n_reset) par_q <= 1'b0;
    else          par_q <= (par_q & ~(clr_w1c & wdata[4])) | par_set;
  end
  assign par_flag = par_q;
`else
  logic unused_par_wdata;
  assign par_flag         = 1'b0;
  assign unused_par_wdata = wdata[4];
`endif

  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:5], wdata[1:0]};

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign irq   = ~empty;

endmodule
